move_checker: RTL

Parametrised multi-cycle collision checker for the Tetris game core. On a request it scans the four cells of the active tetromino at its candidate position (left, right, down or clockwise rotate). It reads each target cell through a synchronous board read port and reports whether the move is legal. It replaces the per-direction single-cycle check modules with one checker covering all seven pieces, all four rotations and any board size.

---
 rtl/move_checker.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/move_checker.sv
// Multi-cycle tetromino collision checker: scans the four target cells through a synchronous board port.
// Optional build macro MOVE_CHECK_EARLY_EXIT_EN ends the scan at the first blocked cell.
module move_checker #(
    parameter int BOARD_W = 16,
    parameter int BOARD_H = 20,
    parameter int CELL_W  = 3,
    localparam int XW = $clog2(BOARD_W),
    localparam int YW = $clog2(BOARD_H)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [1:0]        Dir,
    input  logic [2:0]        Piece,
    input  logic [1:0]        Rot,
    input  logic [XW-1:0]     XPOS,
    input  logic [YW-1:0]     YPOS,
    output logic              RdEn,
    output logic [YW-1:0]     RdRow,
    output logic [XW-1:0]     RdCol,
    input  logic [CELL_W-1:0] RdData,
    output logic              Busy,
    output logic              Done,
    output logic              CanMove,
    output logic [1:0]        NewRot
);
    localparam int CW = ((XW > YW) ? XW : YW) + 2;
    localparam logic signed [CW-1:0] BW_S = CW'(BOARD_W);
    localparam logic signed [CW-1:0] BH_S = CW'(BOARD_H);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Returns {dx, dy} of cell k for piece pc after r clockwise steps.
    function automatic logic [3:0] cell_off(input logic [2:0] pc, input logic [1:0] r,
                                            input logic [1:0] k);
        logic [15:0] rom;
        logic [1:0]  x, y, t;
        int          b;
        case (pc)
            3'd0:    rom = 16'h159D;
            3'd2:    rom = 16'h4159;
            3'd3:    rom = 16'h4815;
            3'd4:    rom = 16'h0459;
            3'd5:    rom = 16'h0159;
            3'd6:    rom = 16'h8159;
            default: rom = 16'h4859;
        endcase
        b = 12 - 4 * int'(k);
        x = rom[b+2 +: 2];
        y = rom[b +: 2];
        for (int i = 0; i < 3; i++) begin
            if (i < int'(r)) begin
                t = x;
                if (pc == 3'd0) begin
                    x = 2'd3 - y;
                    y = t;
                end else if (pc != 3'd1 && pc != 3'd7) begin
                    x = 2'd2 - y;
                    y = t;
                end
            end
        end
        return {x, y};
    endfunction

    logic [1:0]           state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic                 blk_q, blk_d;
    logic                 rdp_q, rdp_d;
    logic                 can_q, can_d;
    logic [1:0]           nrot_q, nrot_d;
    logic [YW-1:0]        row_q;
    logic [XW-1:0]        col_q;

    logic [2:0]           piece_q;
    logic [1:0]           trot_q;
    logic [1:0]           dir_q;
    logic [XW-1:0]        xpos_q;
    logic [YW-1:0]        ypos_q;

    logic                 accept, scan, inb, hit, blk_now, abort;
    logic [3:0]           off;
    logic signed [CW-1:0] mx, my, tx, ty;

    assign accept = Start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        off = cell_off(piece_q, trot_q, idx_q);
        mx  = '0;
        my  = '0;
        case (dir_q)
            2'b00:   mx = '1;
            2'b01:   mx = CW'(1);
            2'b10:   my = CW'(1);
            default: ;
        endcase
        tx      = CW'(xpos_q) + CW'(off[3:2]) + mx;
        ty      = CW'(ypos_q) + CW'(off[1:0]) + my;
        inb     = !tx[CW-1] && (tx < BW_S) && (ty < BH_S);
        scan    = (state_q == S_SCAN);
        RdEn    = scan && inb;
        RdRow   = RdEn ? ty[YW-1:0] : row_q;
        RdCol   = RdEn ? tx[XW-1:0] : col_q;
        // RdData answers the previous cycle's read; stale data after an abort is ignored.
        hit     = rdp_q && (scan || state_q == S_DRAIN) && (RdData != '0);
        blk_now = blk_q || (scan && !inb) || hit;
        abort   = 1'b0;
`ifdef MOVE_CHECK_EARLY_EXIT_EN
        abort   = (scan && !inb) || hit;
`endif
        state_d = state_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        rdp_d   = RdEn;
        can_d   = can_q;
        nrot_d  = nrot_q;
        case (state_q)
            S_SCAN: begin
                blk_d = blk_now;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                blk_d   = blk_now;
                state_d = S_DONE;
            end
            default: begin
                state_d = accept ? S_SCAN : S_IDLE;
                idx_d   = '0;
                blk_d   = 1'b0;
            end
        endcase
        if (abort) state_d = S_DONE;
        if (state_d == S_DONE && state_q != S_DONE) begin
            can_d  = !blk_now;
            nrot_d = trot_q;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            blk_q   <= 1'b0;
            rdp_q   <= 1'b0;
            can_q   <= 1'b0;
            nrot_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            rdp_q   <= rdp_d;
            can_q   <= can_d;
            nrot_q  <= nrot_d;
            row_q   <= RdRow;
            col_q   <= RdCol;
        end
    end

    // Request fields only matter while a scan is in flight, so they carry no reset.
    always_ff @(posedge Clock) begin
        if (accept) begin
            piece_q <= Piece;
            trot_q  <= (Dir == 2'b11) ? Rot + 2'd1 : Rot;
            dir_q   <= Dir;
            xpos_q  <= XPOS;
            ypos_q  <= YPOS;
        end
    end

    assign Busy    = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign Done    = (state_q == S_DONE);
    assign CanMove = can_q;
    assign NewRot  = nrot_q;
endmodule
